// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   XLEN_DEF : default register data width
//   REG_AW   : register address width
//   NREG     : number of architectural registers
//   arb_state_e : arbiter FSM encoding
package rf_ctrl_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam int NREG     = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    HOLD   = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding long-latency results {dest addr, data}.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   push, push_addr/data  : write an entry (ignored when full)
//   pop                   : drop the head entry (ignored when empty)
//   full, empty           : status from the registered occupancy count
//   head_addr, head_data  : oldest entry, valid when !empty
module rf_wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [REG_AW-1:0] push_addr,
  input  logic [XLEN-1:0]   push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [REG_AW-1:0] head_addr,
  output logic [XLEN-1:0]   head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_AW-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file's single write port between pipeline
// writeback (priority) and buffered long-latency unit results, with a
// starvation guard and a per-register pending scoreboard.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   wb_valid, wb_rd_addr, wb_data   : pipeline writeback request
//   lu_valid, lu_ready, lu_rd_addr, lu_data : LU result handshake
//   pend_set, pend_addr             : mark an issued LU destination pending
//   chk_rs1/rs2/rd_addr, hazard     : issue dependency check
//   wb_stall                        : registered; pipeline holds WB next cycle
//   rf_we, rf_waddr, rf_wdata       : register file write port
//
// state  | meaning
// NORMAL | WB has priority; count cycles the FIFO loses the port
// HOLD   | one cycle, WB stalled so the FIFO head is written
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_rd_addr,
  input  logic [XLEN-1:0]   lu_data,
  input  logic              pend_set,
  input  logic [REG_AW-1:0] pend_addr,
  input  logic [REG_AW-1:0] chk_rs1_addr,
  input  logic [REG_AW-1:0] chk_rs2_addr,
  input  logic [REG_AW-1:0] chk_rd_addr,
  output logic              hazard,
  output logic              wb_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall_d;
  logic [NREG-1:0]   pend_q, pend_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [REG_AW-1:0] head_addr;
  logic [XLEN-1:0]   head_data;
  logic              wb_take;

  // x0 results complete the handshake but are never stored.
  assign lu_ready  = !rst && !fifo_full;
  assign fifo_push = lu_valid && lu_ready && (lu_rd_addr != '0);

  rf_wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_addr (lu_rd_addr),
    .push_data (lu_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  // FIFO entries never target x0, so a head write is always real.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    fifo_pop = 1'b0;
    wb_take  = 1'b0;
    if (!rst) begin
      if ((state_q == NORMAL) && wb_valid && (wb_rd_addr != '0)) begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd_addr;
        rf_wdata = wb_data;
        wb_take  = 1'b1;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_waddr = head_addr;
        rf_wdata = head_data;
        fifo_pop = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = wb_stall;
    case (state_q)
      NORMAL: begin
        if (!fifo_empty && wb_take) begin
          if (cnt_q == CNT_W'(STARVE_MAX - 1)) begin
            state_d = HOLD;
            cnt_d   = '0;
            stall_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      HOLD: begin
        state_d = NORMAL;
        cnt_d   = '0;
        stall_d = 1'b0;
      end
      default: begin
        state_d = NORMAL;
        cnt_d   = '0;
        stall_d = 1'b0;
      end
    endcase
  end

  // Set is applied after clear so a same-cycle set on the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (fifo_pop) pend_d[rf_waddr] = 1'b0;
    if (pend_set && (pend_addr != '0)) pend_d[pend_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NORMAL;
      cnt_q    <= '0;
      wb_stall <= 1'b0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_stall <= stall_d;
      pend_q   <= pend_d;
    end
  end

  assign hazard = !rst && (pend_q[chk_rs1_addr] | pend_q[chk_rs2_addr] | pend_q[chk_rd_addr]);
endmodule
